// File: rtl/uart_cmd_pkg.sv
// Shared definitions for the UART command framer and its downstream decoder.
// Latency: n/a (types, constants and a helper only).
// Backpressure: n/a.
// Contents: parser state encoding, default start-of-frame byte, motion opcodes,
// and a helper telling which parser states are guarded by the inter-byte timer.
package uart_cmd_pkg;

  typedef enum logic [2:0] {
    ST_HUNT    = 3'd0,
    ST_OP      = 3'd1,
    ST_LEN     = 3'd2,
    ST_PAYLOAD = 3'd3,
    ST_CHK     = 3'd4,
    ST_HOLD    = 3'd5
  } state_e;

  localparam logic [7:0] SOF_BYTE_DEFAULT = 8'hA5;

  // Opcodes understood by the motion/extruder decoder.
  localparam logic [7:0] OP_HOME    = 8'h01;
  localparam logic [7:0] OP_MOVE    = 8'h10;
  localparam logic [7:0] OP_EXTRUDE = 8'h20;

  // States that sit inside a frame and therefore run the inter-byte timer.
  function automatic logic is_timed(input state_e s);
    return (s == ST_OP) || (s == ST_LEN) || (s == ST_PAYLOAD) || (s == ST_CHK);
  endfunction

endpackage

// File: rtl/uart_cmd_framer_if.sv
// Byte-in / frame-out bundle between UART receiver, framer and command consumer.
// Latency: n/a (wiring only).
// Backpressure: cmd_valid/cmd_ready handshake; the byte side has none (strobe only).
// Ports: rx_valid/rx_byte (byte strobe in), cmd_valid/cmd_ready/cmd_op/cmd_len/
// cmd_payload (frame out), err_chk/err_len/err_timeout/err_overrun (error pulses).
interface uart_cmd_framer_if #(
  parameter int MAX_PAYLOAD = 8
);
  logic                     rx_valid;
  logic [7:0]               rx_byte;
  logic                     cmd_valid;
  logic                     cmd_ready;
  logic [7:0]               cmd_op;
  logic [3:0]               cmd_len;
  logic [8*MAX_PAYLOAD-1:0] cmd_payload;
  logic                     err_chk;
  logic                     err_len;
  logic                     err_timeout;
  logic                     err_overrun;

  // master: the framer itself.
  modport master (
    input  rx_valid, rx_byte, cmd_ready,
    output cmd_valid, cmd_op, cmd_len, cmd_payload,
    output err_chk, err_len, err_timeout, err_overrun
  );

  // slave: the receiver/consumer side that feeds bytes and takes frames.
  modport slave (
    output rx_valid, rx_byte, cmd_ready,
    input  cmd_valid, cmd_op, cmd_len, cmd_payload,
    input  err_chk, err_len, err_timeout, err_overrun
  );
endinterface

// File: rtl/uart_cmd_timeout.sv
// Inter-byte gap timer: loadable down-counter, expires after TIMEOUT_CYCLES-1 idle steps.
// Latency: expire is combinational from the registered count.
// Backpressure: none.
// Ports: clk_50MHz, reset (sync, active-high), clr (force 0), load (reload full
// interval), en (count down / allow expiry), expire (interval used up this cycle).
module uart_cmd_timeout #(
  parameter int TIMEOUT_CYCLES = 500000
) (
  input  logic clk_50MHz,
  input  logic reset,
  input  logic clr,
  input  logic load,
  input  logic en,
  output logic expire
);

  localparam int W = $clog2(TIMEOUT_CYCLES);
  localparam logic [W-1:0] LOAD_VAL = W'(TIMEOUT_CYCLES - 1);

  logic [W-1:0] cnt_q, cnt_d;

  // Reaching zero while enabled means TIMEOUT_CYCLES-1 idle cycles have
  // elapsed since the last load and this is the final allowed cycle.
  assign expire = en && (cnt_q == '0);

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (load) begin
      cnt_d = LOAD_VAL;
    end else if (en && (cnt_q != '0)) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk_50MHz) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_cmd_framer.sv
// Command-frame parser: SOF, OP, LEN, payload, XOR checksum -> one held command.
// Latency: cmd_valid and error pulses appear one edge after the causing byte strobe.
// Backpressure: a good frame is held until cmd_ready; bytes arriving meanwhile are
// dropped with err_overrun, except on the handshake cycle where they are parsed.
// Ports: clk_50MHz, reset (sync, active-high), bus (uart_cmd_framer_if.master).
module uart_cmd_framer
  import uart_cmd_pkg::*;
#(
  parameter int         MAX_PAYLOAD    = 8,
  parameter int         TIMEOUT_CYCLES = 500000,
  parameter logic [7:0] SOF_BYTE       = SOF_BYTE_DEFAULT
) (
  input  logic              clk_50MHz,
  input  logic              reset,
  uart_cmd_framer_if.master bus
);

  localparam int PW = 8 * MAX_PAYLOAD;

  state_e          state_q, state_d;
  logic [7:0]      op_q, op_d;
  logic [7:0]      acc_q, acc_d;
  logic [3:0]      len_q, len_d;
  logic [3:0]      idx_q, idx_d;
  logic [PW-1:0]   payload_q, payload_d;
  logic            valid_q, valid_d;
  logic            err_chk_q, err_chk_d;
  logic            err_len_q, err_len_d;
  logic            err_timeout_q, err_timeout_d;
  logic            err_overrun_q, err_overrun_d;
  logic            tmo_clr, tmo_load, tmo_en, tmo_expire;
  logic            rx_valid;
  logic [7:0]      rx_byte;
  logic            is_sof;

  assign rx_valid = bus.rx_valid;
  assign rx_byte  = bus.rx_byte;
  assign is_sof   = rx_valid && (rx_byte == SOF_BYTE);

  always_comb begin
    state_d       = state_q;
    op_d          = op_q;
    acc_d         = acc_q;
    len_d         = len_q;
    idx_d         = idx_q;
    payload_d     = payload_q;
    err_chk_d     = 1'b0;
    err_len_d     = 1'b0;
    err_timeout_d = 1'b0;
    err_overrun_d = 1'b0;

    case (state_q)
      ST_HUNT: begin
        if (is_sof) begin
          state_d   = ST_OP;
          payload_d = '0;
          acc_d     = '0;
        end
      end
      ST_OP: begin
        if (rx_valid) begin
          op_d    = rx_byte;
          acc_d   = rx_byte;
          state_d = ST_LEN;
        end
      end
      ST_LEN: begin
        if (rx_valid) begin
          if (rx_byte > 8'(MAX_PAYLOAD)) begin
            err_len_d = 1'b1;
            state_d   = ST_HUNT;
          end else begin
            len_d   = rx_byte[3:0];
            acc_d   = acc_q ^ rx_byte;
            idx_d   = '0;
            state_d = (rx_byte != 8'd0) ? ST_PAYLOAD : ST_CHK;
          end
        end
      end
      ST_PAYLOAD: begin
        if (rx_valid) begin
          for (int i = 0; i < MAX_PAYLOAD; i++) begin
            if (idx_q == 4'(i)) begin
              payload_d[8*i +: 8] = rx_byte;
            end
          end
          acc_d = acc_q ^ rx_byte;
          idx_d = idx_q + 4'd1;
          if (idx_q == (len_q - 4'd1)) begin
            state_d = ST_CHK;
          end
        end
      end
      ST_CHK: begin
        if (rx_valid) begin
          if (rx_byte == acc_q) begin
            state_d = ST_HOLD;
          end else begin
            err_chk_d = 1'b1;
            state_d   = ST_HUNT;
          end
        end
      end
      ST_HOLD: begin
        // The handshake cycle behaves like HUNT so back-to-back frames are not lost.
        if (bus.cmd_ready) begin
          state_d = ST_HUNT;
          if (is_sof) begin
            state_d   = ST_OP;
            payload_d = '0;
            acc_d     = '0;
          end
        end else if (rx_valid) begin
          err_overrun_d = 1'b1;
        end
      end
      default: state_d = ST_HUNT;
    endcase

    // Expiry only fires inside a frame; a byte on the expiry cycle takes precedence.
    if (tmo_expire && !rx_valid) begin
      state_d       = ST_HUNT;
      err_timeout_d = 1'b1;
    end

    valid_d  = (state_d == ST_HOLD);
    tmo_en   = is_timed(state_q);
    tmo_load = rx_valid && is_timed(state_d);
    tmo_clr  = !is_timed(state_d);
  end

  always_ff @(posedge clk_50MHz) begin
    if (reset) begin
      state_q       <= ST_HUNT;
      op_q          <= '0;
      acc_q         <= '0;
      len_q         <= '0;
      idx_q         <= '0;
      payload_q     <= '0;
      valid_q       <= 1'b0;
      err_chk_q     <= 1'b0;
      err_len_q     <= 1'b0;
      err_timeout_q <= 1'b0;
      err_overrun_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      op_q          <= op_d;
      acc_q         <= acc_d;
      len_q         <= len_d;
      idx_q         <= idx_d;
      payload_q     <= payload_d;
      valid_q       <= valid_d;
      err_chk_q     <= err_chk_d;
      err_len_q     <= err_len_d;
      err_timeout_q <= err_timeout_d;
      err_overrun_q <= err_overrun_d;
    end
  end

  uart_cmd_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk_50MHz(clk_50MHz),
    .reset    (reset),
    .clr      (tmo_clr),
    .load     (tmo_load),
    .en       (tmo_en),
    .expire   (tmo_expire)
  );

  assign bus.cmd_valid   = valid_q;
  assign bus.cmd_op      = op_q;
  assign bus.cmd_len     = len_q;
  assign bus.cmd_payload = payload_q;
  assign bus.err_chk     = err_chk_q;
  assign bus.err_len     = err_len_q;
  assign bus.err_timeout = err_timeout_q;
  assign bus.err_overrun = err_overrun_q;

endmodule

// File: tb/tb_uart_cmd_framer.sv
// Bench for uart_cmd_framer: directed frames plus randomized byte streams.
// Expected outputs come from a frame-level queue model of the byte stream.
module tb_uart_cmd_framer;
  import uart_cmd_pkg::*;

  localparam int MAXP = 8;
  localparam int TMO  = 100;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  uart_cmd_framer_if #(.MAX_PAYLOAD(MAXP)) bus ();

  uart_cmd_framer #(
    .MAX_PAYLOAD   (MAXP),
    .TIMEOUT_CYCLES(TMO),
    .SOF_BYTE      (SOF_BYTE_DEFAULT)
  ) dut (
    .clk_50MHz(clk),
    .reset    (reset),
    .bus      (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  // ---------------- reference model (frame-level, queue based) ----------------
  bit          m_in_frame, m_hold;
  int          m_gap;
  logic [7:0]  m_q[$];
  bit          e_valid, e_chk, e_len, e_to, e_ovr, e_zero;
  logic [7:0]  e_op;
  logic [3:0]  e_lenv;
  logic [63:0] e_pl;

  task automatic model_reset();
    m_in_frame = 0; m_hold = 0; m_gap = 0; m_q.delete();
    e_valid = 0; e_chk = 0; e_len = 0; e_to = 0; e_ovr = 0;
    e_zero = 1; e_op = '0; e_lenv = '0; e_pl = '0;
  endtask

  task automatic start_frame();
    m_in_frame = 1; m_q.delete(); m_gap = 0;
  endtask

  task automatic model_step(input bit v, input logic [7:0] b, input bit rdy);
    logic [7:0] x;
    e_chk = 0; e_len = 0; e_to = 0; e_ovr = 0; e_zero = 0;
    if (m_hold) begin
      if (rdy) begin
        m_hold = 0;
        if (v && b == SOF_BYTE_DEFAULT) start_frame();
      end else if (v) begin
        e_ovr = 1;
      end
    end else if (m_in_frame) begin
      if (v) begin
        m_q.push_back(b);
        m_gap = 0;
        if (m_q.size() == 2 && int'(b) > MAXP) begin
          e_len = 1; m_in_frame = 0;
        end else if (m_q.size() >= 2 && m_q.size() == int'(m_q[1]) + 3) begin
          x = '0;
          for (int i = 0; i < m_q.size() - 1; i++) x ^= m_q[i];
          m_in_frame = 0;
          if (x == b) begin
            m_hold = 1;
            e_op   = m_q[0];
            e_lenv = m_q[1][3:0];
            e_pl   = '0;
            for (int i = 0; i < int'(m_q[1]); i++) e_pl[8*i +: 8] = m_q[2+i];
          end else begin
            e_chk = 1;
          end
        end
      end else begin
        m_gap++;
        if (m_gap == TMO) begin
          e_to = 1; m_in_frame = 0;
        end
      end
    end else if (v && b == SOF_BYTE_DEFAULT) begin
      start_frame();
    end
    e_valid = m_hold;
  endtask

  task automatic check_outputs();
    check_eq("cmd_valid",   64'(bus.cmd_valid),   64'(e_valid));
    check_eq("err_chk",     64'(bus.err_chk),     64'(e_chk));
    check_eq("err_len",     64'(bus.err_len),     64'(e_len));
    check_eq("err_timeout", 64'(bus.err_timeout), 64'(e_to));
    check_eq("err_overrun", 64'(bus.err_overrun), 64'(e_ovr));
    if (e_valid || e_zero) begin
      check_eq("cmd_op",      64'(bus.cmd_op),      64'(e_op));
      check_eq("cmd_len",     64'(bus.cmd_len),     64'(e_lenv));
      check_eq("cmd_payload", 64'(bus.cmd_payload), e_pl);
    end
  endtask

  // One clock: check what the previous edge produced, then drive the next cycle.
  task automatic cyc(input bit rst, input bit v, input logic [7:0] b, input bit rdy);
    @(negedge clk);
    check_outputs();
    reset        = rst;
    bus.rx_valid = v;
    bus.rx_byte  = b;
    bus.cmd_ready = rdy;
    if (rst) model_reset();
    else     model_step(v, b, rdy);
  endtask

  task automatic send(input logic [7:0] b, input bit rdy);
    cyc(1'b0, 1'b1, b, rdy);
  endtask

  task automatic idle(input int n, input bit rdy);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 8'h00, rdy);
  endtask

  logic [7:0] seq[$];

  task automatic send_seq(input bit rdy);
    foreach (seq[i]) send(seq[i], rdy);
  endtask

  initial begin
    reset         = 1'b1;
    bus.rx_valid  = 1'b0;
    bus.rx_byte   = 8'h00;
    bus.cmd_ready = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    cyc(1'b1, 1'b0, 8'h00, 1'b0);   // checks reset state

    // Good frame, consumer always ready.
    seq = '{8'hA5, OP_MOVE, 8'h02, 8'h34, 8'h56, 8'h70}; send_seq(1'b1); idle(3, 1'b1);
    // Zero-length frame held under backpressure, then released.
    seq = '{8'hA5, OP_HOME, 8'h00, 8'h01}; send_seq(1'b0); idle(20, 1'b0); idle(3, 1'b1);
    // Checksum error followed by a good frame.
    seq = '{8'hA5, OP_MOVE, 8'h02, 8'h34, 8'h56, 8'h71}; send_seq(1'b1); idle(2, 1'b1);
    seq = '{8'hA5, OP_MOVE, 8'h02, 8'h34, 8'h56, 8'h70}; send_seq(1'b1); idle(2, 1'b1);
    // Oversized length; trailing bytes must be ignored.
    seq = '{8'hA5, OP_MOVE, 8'h09, 8'h34, 8'h56}; send_seq(1'b1); idle(2, 1'b1);
    // Full idle gap times out; a byte on the last allowed cycle survives.
    seq = '{8'hA5, OP_MOVE}; send_seq(1'b1); idle(TMO, 1'b1); idle(2, 1'b1);
    seq = '{8'hA5, OP_MOVE}; send_seq(1'b1); idle(TMO - 1, 1'b1);
    seq = '{8'h02, 8'h34, 8'h56, 8'h70}; send_seq(1'b1); idle(2, 1'b1);
    // Overrun while held, then SOF on the handshake cycle starts the next frame.
    seq = '{8'hA5, OP_EXTRUDE, 8'h01, 8'h33, 8'h12}; send_seq(1'b0); idle(2, 1'b0);
    send(8'h22, 1'b0); idle(2, 1'b0);
    seq = '{8'hA5, OP_HOME, 8'h00, 8'h01}; send_seq(1'b1); idle(2, 1'b1);
    // Reset mid-payload, then a clean frame.
    seq = '{8'hA5, OP_MOVE, 8'h03, 8'h11, 8'h22}; send_seq(1'b1);
    cyc(1'b1, 1'b0, 8'h00, 1'b1);
    seq = '{8'hA5, OP_EXTRUDE, 8'h01, 8'h33, 8'h12}; send_seq(1'b1); idle(2, 1'b1);

    // Randomized frames with corrupt checksums, bad lengths, long gaps, noise and resets.
    for (int f = 0; f < 150; f++) begin
      int         len;
      int         gap;
      logic [7:0] x;
      seq.delete();
      len = int'($urandom_range(0, 10));
      seq.push_back(8'hA5);
      seq.push_back(8'($urandom));
      seq.push_back(8'(len));
      x = seq[1] ^ seq[2];
      for (int i = 0; i < len; i++) begin
        seq.push_back(8'($urandom));
        x ^= seq[3+i];
      end
      if ($urandom_range(0, 5) == 0) x ^= 8'(1 << $urandom_range(0, 7));
      seq.push_back(x);
      foreach (seq[i]) begin
        gap = ($urandom_range(0, 19) == 0) ? int'($urandom_range(TMO - 3, TMO + 2))
                                           : int'($urandom_range(0, 3));
        for (int g = 0; g < gap; g++) cyc(1'b0, 1'b0, 8'h00, $urandom_range(0, 3) != 0);
        if ($urandom_range(0, 199) == 0) cyc(1'b1, 1'b0, 8'h00, 1'b1);
        if ($urandom_range(0, 29) == 0) send(8'($urandom), $urandom_range(0, 3) != 0);
        send(seq[i], $urandom_range(0, 3) != 0);
      end
    end
    idle(5, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
